serial_subtractor: RTL

//   Bit-serial WIDTH-bit subtractor. It is the inverse-operation counterpart of
//   the ripple full_adder datapath. Each cycle it runs one full-subtractor cell,

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// slave = the subtractor, master = whoever feeds operands and consumes results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, minuend, subtrahend, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, minuend, subtrahend, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (A - B - borrow_in), one full-subtractor cell per cycle, LSB first.
// Result valid WIDTH cycles after accept; in_ready low while busy, result held in DONE until out_ready.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  io
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_out_q, borrow_out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Full-subtractor cell: two half-subtractors and a borrow OR.
  logic d1, b1, d_bit, b2, br_next;

  always_comb begin
    d1      = a_sr_q[0] ^ b_sr_q[0];
    b1      = ~a_sr_q[0] & b_sr_q[0];
    d_bit   = d1 ^ br_q;
    b2      = ~d1 & br_q;
    br_next = b1 | b2;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    diff_d       = diff_q;
    br_d         = br_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          a_sr_d  = io.minuend;
          b_sr_d  = io.subtrahend;
          br_d    = io.borrow_in;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {d_bit, res_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        br_d    = br_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          // The last difference bit bypasses res_q so diff is complete on entry to DONE.
          diff_d       = {d_bit, res_q[WIDTH-1:1]};
          borrow_out_d = br_next;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they line up with state_q.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      br_q         <= br_d;
      borrow_out_q <= borrow_out_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.busy       = busy_q;
  assign io.diff       = diff_q;
  assign io.borrow_out = borrow_out_q;

endmodule
